// File: rtl/spl_afu_pkg.sv
// Widths and drain FSM encoding shared by the AFU write arbiter and its sub-blocks.
// Header and data widths match the CCI TX write channel.
package spl_afu_pkg;
  localparam int TX_HDR_W = 99;
  localparam int DATA_W   = 512;
  localparam int RX_HDR_W = 18;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drain_state_t;
endpackage

// File: rtl/afu_rr_arb2.sv
// Two-way round-robin grant, combinational from valid/enable and the last winner.
// last_grant only moves when a grant is issued, so an idle cycle never changes priority.
module afu_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid_i,
  input  logic       enable_i,
  output logic [1:0] grant_o
);
  logic last_grant_q;

  always_comb begin
    grant_o = 2'b00;
    if (enable_i) begin
      unique case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else if (|grant_o) begin
      last_grant_q <= grant_o[1];
    end
  end
endmodule

// File: rtl/afu_wr_arbiter.sv
// Shares the AFU TX write channel between a stream engine (0) and a status writer (1),
// with almost-full backpressure, an outstanding-write cap and a drain handshake.
module afu_wr_arbiter
  import spl_afu_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 64,
  parameter int CNT_W           = 8
) (
  input  logic                vl_clk_LPdomain_32ui,
  input  logic                ffs_vl_LP32ui_lp2sy_SystemReset_n,
  input  logic                req0_valid,
  input  logic [TX_HDR_W-1:0] req0_hdr,
  input  logic [DATA_W-1:0]   req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [TX_HDR_W-1:0] req1_hdr,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                req1_ready,
  input  logic                spl_tx_wr_almostfull,
  output logic                afu_tx_wr_valid,
  output logic [TX_HDR_W-1:0] afu_tx_wr_hdr,
  output logic [DATA_W-1:0]   afu_tx_data,
  input  logic                spl_rx_wr_valid0,
  input  logic                spl_rx_wr_valid1,
  input  logic                drain_req,
  output logic                drain_done,
  output logic [CNT_W-1:0]    outstanding,
  output logic                err_underflow
);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic                clk;
  logic                rst_n;
  logic                can_issue;
  logic [1:0]          grant;
  logic                accept;
  logic [CNT_W:0]      inc_sum;
  logic [CNT_W:0]      dec_ext;
  logic [CNT_W:0]      diff;
  logic                underflow;
  logic [CNT_W-1:0]    out_d;

  logic                tx_vld_q;
  logic [TX_HDR_W-1:0] tx_hdr_q;
  logic [DATA_W-1:0]   tx_dat_q;
  logic [CNT_W-1:0]    out_q;
  logic                err_q;
  drain_state_t        state_q;
  logic                done_q;

  assign clk   = vl_clk_LPdomain_32ui;
  assign rst_n = ffs_vl_LP32ui_lp2sy_SystemReset_n;

  // The counter already includes the write sitting in the output register.
  assign can_issue = !spl_tx_wr_almostfull && (out_q < MAX_CNT) && (state_q == RUN);

  afu_rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  ({req1_valid, req0_valid}),
    .enable_i (can_issue),
    .grant_o  (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;

  always_comb begin
    inc_sum   = {1'b0, out_q} + {{CNT_W{1'b0}}, accept};
    dec_ext   = {{(CNT_W-1){1'b0}}, 2'({1'b0, spl_rx_wr_valid0} + {1'b0, spl_rx_wr_valid1})};
    diff      = inc_sum - dec_ext;
    underflow = inc_sum < dec_ext;
    out_d     = underflow ? '0 : diff[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_vld_q <= 1'b0;
      tx_hdr_q <= '0;
      tx_dat_q <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      tx_vld_q <= accept;
      if (accept) begin
        tx_hdr_q <= grant[1] ? req1_hdr  : req0_hdr;
        tx_dat_q <= grant[1] ? req1_data : req0_data;
      end
      out_q <= out_d;
      if (underflow) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          done_q <= 1'b0;
          if (drain_req) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!drain_req) begin
            state_q <= RUN;
          end else if (out_q == '0 && !tx_vld_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          if (!drain_req) begin
            state_q <= RUN;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= RUN;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign afu_tx_wr_valid = tx_vld_q;
  assign afu_tx_wr_hdr   = tx_hdr_q;
  assign afu_tx_data     = tx_dat_q;
  assign outstanding     = out_q;
  assign err_underflow   = err_q;
  assign drain_done      = done_q;
endmodule

// File: tb/tb_afu_wr_arbiter.sv
// Table-driven bench for afu_wr_arbiter with MAX_OUTSTANDING=4; issued writes are
// checked against a queue of expected header/data filled when an accept is expected.
module tb_afu_wr_arbiter;
  localparam int MAXO = 4;
  localparam int CW   = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [98:0]  req0_hdr, req1_hdr, tx_hdr;
  logic [511:0] req0_data, req1_data, tx_data;
  logic         almostfull, tx_valid, rx0, rx1, drain_req, drain_done, err_uf;
  logic [CW-1:0] outstanding;

  always #5 clk = ~clk;

  afu_wr_arbiter #(.MAX_OUTSTANDING(MAXO), .CNT_W(CW)) dut (
    .vl_clk_LPdomain_32ui              (clk),
    .ffs_vl_LP32ui_lp2sy_SystemReset_n (rst_n),
    .req0_valid           (req0_valid),
    .req0_hdr             (req0_hdr),
    .req0_data            (req0_data),
    .req0_ready           (req0_ready),
    .req1_valid           (req1_valid),
    .req1_hdr             (req1_hdr),
    .req1_data            (req1_data),
    .req1_ready           (req1_ready),
    .spl_tx_wr_almostfull (almostfull),
    .afu_tx_wr_valid      (tx_valid),
    .afu_tx_wr_hdr        (tx_hdr),
    .afu_tx_data          (tx_data),
    .spl_rx_wr_valid0     (rx0),
    .spl_rx_wr_valid1     (rx1),
    .drain_req            (drain_req),
    .drain_done           (drain_done),
    .outstanding          (outstanding),
    .err_underflow        (err_uf)
  );

  typedef struct {
    logic v0, v1, af, r0, r1, drn;
    logic e_rdy0, e_rdy1;
    int   e_out;
    logic e_done, e_err;
  } vec_t;

  vec_t         vecs[$];
  logic [98:0]  exp_hdr_q[$];
  logic [511:0] exp_dat_q[$];
  logic [98:0]  last_hdr;
  logic [511:0] last_dat;
  int           checks = 0;
  int           errors = 0;
  int           seq = 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v0, v1, af, r0, r1, drn, e0, e1,
                     input int eo, input logic ed, ee);
    vec_t v;
    v = '{v0, v1, af, r0, r1, drn, e0, e1, eo, ed, ee};
    vecs.push_back(v);
  endtask

  task automatic new_req(input int which);
    if (which == 0) begin
      req0_hdr  = {1'b0, 98'(seq)};
      req0_data = {16{32'(seq)}};
    end else begin
      req1_hdr  = {1'b1, 98'(seq)};
      req1_data = ~{16{32'(seq)}};
    end
    seq++;
  endtask

  initial begin
    //   v0 v1 af r0 r1 dr  e0 e1 out done err
    add(1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0);  // alternation starts at requester 0
    add(1, 1, 0, 1, 0, 0,  0, 1, 1, 0, 0);
    add(1, 1, 0, 1, 0, 0,  1, 0, 1, 0, 0);
    add(1, 1, 0, 0, 1, 0,  0, 1, 1, 0, 0);
    add(1, 0, 0, 1, 0, 0,  1, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0);  // fill to the cap
    add(1, 0, 0, 0, 0, 0,  1, 0, 2, 0, 0);
    add(1, 0, 0, 0, 0, 0,  1, 0, 3, 0, 0);
    add(1, 0, 0, 0, 0, 0,  1, 0, 4, 0, 0);
    add(1, 0, 0, 0, 0, 0,  0, 0, 4, 0, 0);
    add(1, 0, 0, 0, 1, 0,  0, 0, 3, 0, 0);
    add(1, 0, 0, 0, 0, 0,  1, 0, 4, 0, 0);
    add(1, 0, 0, 1, 1, 0,  0, 0, 2, 0, 0);
    add(1, 0, 0, 0, 0, 0,  1, 0, 3, 0, 0);  // almost-full right after an accept
    add(1, 0, 1, 0, 0, 0,  0, 0, 3, 0, 0);
    add(1, 0, 1, 0, 0, 0,  0, 0, 3, 0, 0);
    add(1, 0, 0, 1, 1, 0,  1, 0, 2, 0, 0);  // accept + two responses from 3
    add(0, 1, 0, 1, 1, 0,  0, 1, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0,  0, 1, 2, 0, 0);
    add(0, 0, 0, 0, 0, 1,  0, 0, 2, 0, 0);  // drain with 2 outstanding
    add(1, 1, 0, 0, 0, 1,  0, 0, 2, 0, 0);
    add(1, 1, 0, 1, 0, 1,  0, 0, 1, 0, 0);
    add(1, 1, 0, 0, 1, 1,  0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1,  0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 1,  0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1);  // underflow
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0,  1, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 1);  // drain aborted mid-way
    add(1, 0, 0, 0, 0, 1,  0, 0, 1, 0, 1);
    add(1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1);
    add(1, 0, 0, 0, 0, 0,  1, 0, 2, 0, 1);

    rst_n = 1'b0;
    {req0_valid, req1_valid, almostfull, rx0, rx1, drain_req} = '0;
    new_req(0);
    new_req(1);
    last_hdr = '0;
    last_dat = '0;
    #3;
    chk("reset tx_valid", 512'(tx_valid), 512'(0));
    chk("reset tx_hdr", 512'(tx_hdr), 512'(0));
    chk("reset tx_data", tx_data, 512'(0));
    chk("reset outstanding", 512'(outstanding), 512'(0));
    chk("reset drain_done", 512'(drain_done), 512'(0));
    chk("reset err", 512'(err_uf), 512'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      req0_valid = v.v0; req1_valid = v.v1; almostfull = v.af;
      rx0 = v.r0; rx1 = v.r1; drain_req = v.drn;
      #1;
      chk($sformatf("rdy0[%0d]", i), 512'(req0_ready), 512'(v.e_rdy0));
      chk($sformatf("rdy1[%0d]", i), 512'(req1_ready), 512'(v.e_rdy1));
      if (v.v0 && v.e_rdy0) begin
        exp_hdr_q.push_back(req0_hdr);
        exp_dat_q.push_back(req0_data);
      end else if (v.v1 && v.e_rdy1) begin
        exp_hdr_q.push_back(req1_hdr);
        exp_dat_q.push_back(req1_data);
      end
      @(posedge clk);
      #1;
      if (exp_hdr_q.size() > 0) begin
        chk($sformatf("tx_valid[%0d]", i), 512'(tx_valid), 512'(1));
        last_hdr = exp_hdr_q.pop_front();
        last_dat = exp_dat_q.pop_front();
      end else begin
        chk($sformatf("tx_valid[%0d]", i), 512'(tx_valid), 512'(0));
      end
      chk($sformatf("tx_hdr[%0d]", i), 512'(tx_hdr), 512'(last_hdr));
      chk($sformatf("tx_data[%0d]", i), tx_data, last_dat);
      chk($sformatf("outstanding[%0d]", i), 512'(outstanding), 512'(v.e_out));
      chk($sformatf("drain_done[%0d]", i), 512'(drain_done), 512'(v.e_done));
      chk($sformatf("err[%0d]", i), 512'(err_uf), 512'(v.e_err));
      if (v.v0 && v.e_rdy0) new_req(0);
      if (v.v1 && v.e_rdy1) new_req(1);
    end

    // Asynchronous reset mid-cycle with a write in flight and err set.
    #2 rst_n = 1'b0;
    #1;
    chk("async rst tx_valid", 512'(tx_valid), 512'(0));
    chk("async rst outstanding", 512'(outstanding), 512'(0));
    chk("async rst err", 512'(err_uf), 512'(0));
    chk("async rst drain_done", 512'(drain_done), 512'(0));
    chk("async rst rdy0", 512'(req0_ready), 512'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
